// File: rtl/rotation_sequencer_pkg.sv
// Shared definitions for the rotation sequencer: ALU opcodes, slot-index
// encodings and the 3-bit rotation codes carried in an order word.
package rotation_sequencer_pkg;

    // STORE sits at zero so the reset/idle opcode is also the all-zero pattern
    localparam logic [3:0] ALU_STORE     = 4'd0;
    localparam logic [3:0] ALU_RX90      = 4'd1;
    localparam logic [3:0] ALU_RX180     = 4'd2;
    localparam logic [3:0] ALU_RX270     = 4'd3;
    localparam logic [3:0] ALU_RY90      = 4'd4;
    localparam logic [3:0] ALU_RY180     = 4'd5;
    localparam logic [3:0] ALU_RY270     = 4'd6;
    localparam logic [3:0] ALU_RZ90      = 4'd7;
    localparam logic [3:0] ALU_RZ180     = 4'd8;
    localparam logic [3:0] ALU_REFERENCE = 4'd9;
    localparam logic [3:0] ALU_COMP      = 4'd10;

    localparam logic [2:0] FIRST   = 3'd0;
    localparam logic [2:0] SECOND  = 3'd1;
    localparam logic [2:0] THIRD   = 3'd2;
    localparam logic [2:0] FOURTH  = 3'd3;
    localparam logic [2:0] FIFTH   = 3'd4;
    localparam logic [2:0] SIXTH   = 3'd5;
    localparam logic [2:0] SEVENTH = 3'd6;

    localparam logic [2:0] CODE_RX90  = 3'd0;
    localparam logic [2:0] CODE_RX180 = 3'd1;
    localparam logic [2:0] CODE_RX270 = 3'd2;
    localparam logic [2:0] CODE_RY90  = 3'd3;
    localparam logic [2:0] CODE_RY180 = 3'd4;
    localparam logic [2:0] CODE_RY270 = 3'd5;
    localparam logic [2:0] CODE_RZ90  = 3'd6;
    localparam logic [2:0] CODE_RZ180 = 3'd7;

endpackage

// File: rtl/rotation_sequencer_rot_code_decode.sv
// Maps a 3-bit rotation code from the order word onto the ALU rotation opcode.
module rot_code_decode
    import rotation_sequencer_pkg::*;
(
    input  logic [2:0] code,
    output logic [3:0] op
);

    always_comb begin
        op = ALU_STORE;
        case (code)
            CODE_RX90:  op = ALU_RX90;
            CODE_RX180: op = ALU_RX180;
            CODE_RX270: op = ALU_RX270;
            CODE_RY90:  op = ALU_RY90;
            CODE_RY180: op = ALU_RY180;
            CODE_RY270: op = ALU_RY270;
            CODE_RZ90:  op = ALU_RZ90;
            CODE_RZ180: op = ALU_RZ180;
            default:    op = ALU_STORE;
        endcase
    end

endmodule

// File: rtl/rotation_sequencer.sv
// Walks one order word slot by slot through the external cube ALU
// (fetch code, rotate, compare) and stops on a match or after len slots.
module rotation_sequencer
    import rotation_sequencer_pkg::*;
#(
    parameter int unsigned W          = 24,
    parameter int unsigned SLOTS      = 7,
    parameter int unsigned EARLY_EXIT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] order_in,
    input  logic [W-1:0] cube_in,
    input  logic [W-1:0] target_in,
    output logic         busy,
    output logic         done,
    output logic         solved,
    output logic [2:0]   steps,
    output logic [W-1:0] cube_out,
    output logic [3:0]   alu_op,
    output logic [W-1:0] alu_ina,
    output logic [W-1:0] alu_inb,
    input  logic [W-1:0] alu_out,
    input  logic         alu_zf
);

    localparam int unsigned SLOT_BITS = 3 * SLOTS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FETCH,
        S_ROTATE,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t       state, state_nx;
    logic [W-1:0] order_q;
    logic [W-1:0] target_q;
    logic [W-1:0] cube_q;
    logic [2:0]   idx;
    logic [2:0]   code;
    logic         match;
    logic [2:0]   len;
    logic [3:0]   rot_op;
    logic         early_hit;

    assign len       = order_q[W-1 -: 3];
    assign early_hit = alu_zf && (EARLY_EXIT != 0);
    assign cube_out  = cube_q;

    rot_code_decode u_decode (
        .code (code),
        .op   (rot_op)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            order_q  <= '0;
            target_q <= '0;
            cube_q   <= '0;
            idx      <= FIRST;
            code     <= '0;
            match    <= 1'b0;
            steps    <= '0;
            solved   <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        order_q  <= order_in;
                        cube_q   <= cube_in;
                        target_q <= target_in;
                        idx      <= FIRST;
                        steps    <= '0;
                        solved   <= 1'b0;
                    end
                end
                S_LOAD:  match <= alu_zf;
                S_FETCH: code  <= alu_out[W-1 -: 3];
                S_ROTATE: begin
                    cube_q <= alu_out;
                    steps  <= steps + 3'd1;
                end
                S_COMPARE: begin
                    match <= alu_zf;
                    // only advance when another slot follows, so idx stays within FIRST..SEVENTH
                    if (state_nx == S_FETCH) begin
                        idx <= idx + 3'd1;
                    end
                end
                S_DONE:  solved <= match;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        alu_op   = ALU_STORE;
        alu_ina  = '0;
        alu_inb  = '0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_LOAD;
                end
            end
            S_LOAD: begin
                busy    = 1'b1;
                alu_op  = ALU_COMP;
                alu_ina = cube_q;
                alu_inb = target_q;
                state_nx = (early_hit || len == 3'd0) ? S_DONE : S_FETCH;
            end
            S_FETCH: begin
                busy     = 1'b1;
                alu_op   = ALU_REFERENCE;
                alu_inb  = {idx, order_q[SLOT_BITS-1:0]};
                state_nx = S_ROTATE;
            end
            S_ROTATE: begin
                busy     = 1'b1;
                alu_op   = rot_op;
                alu_inb  = cube_q;
                state_nx = S_COMPARE;
            end
            S_COMPARE: begin
                busy    = 1'b1;
                alu_op  = ALU_COMP;
                alu_ina = cube_q;
                alu_inb = target_q;
                state_nx = (early_hit || steps == len) ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_rotation_sequencer.sv
// Bench for rotation_sequencer with a behavioural cube ALU and a field-level
// reference model of the expected outcome of each order word.
module tb_rotation_sequencer;
    import rotation_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [23:0] order_in, cube_in, target_in;
    logic        busy, done, solved;
    logic [2:0]  steps;
    logic [23:0] cube_out, alu_ina, alu_inb, alu_out;
    logic [3:0]  alu_op;
    logic        alu_zf;

    int vectors     = 0;
    int miscompares = 0;
    int done_cnt    = 0;
    int ref_cnt     = 0;
    int bad_ina     = 0;
    int bad_idx     = 0;

    always #5 clk = ~clk;

    rotation_sequencer #(.W(24), .SLOTS(7), .EARLY_EXIT(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .order_in  (order_in),
        .cube_in   (cube_in),
        .target_in (target_in),
        .busy      (busy),
        .done      (done),
        .solved    (solved),
        .steps     (steps),
        .cube_out  (cube_out),
        .alu_op    (alu_op),
        .alu_ina   (alu_ina),
        .alu_inb   (alu_inb),
        .alu_out   (alu_out),
        .alu_zf    (alu_zf)
    );

    // Cube ALU: X turns rotate the low 12 bits, Y the high 12, Z the whole word.
    function automatic logic [11:0] rot12(input logic [11:0] x, input int s);
        logic [23:0] t;
        t = {x, x};
        return t[s +: 12];
    endfunction

    function automatic logic [23:0] rot24(input logic [23:0] x, input int s);
        logic [47:0] t;
        t = {x, x};
        return t[s +: 24];
    endfunction

    always_comb begin
        logic [2:0] ridx;
        alu_out = '0;
        ridx    = alu_inb[23:21];
        case (alu_op)
            ALU_STORE:     alu_out = alu_inb;
            ALU_RX90:      alu_out = {alu_inb[23:12], rot12(alu_inb[11:0], 3)};
            ALU_RX180:     alu_out = {alu_inb[23:12], rot12(alu_inb[11:0], 6)};
            ALU_RX270:     alu_out = {alu_inb[23:12], rot12(alu_inb[11:0], 9)};
            ALU_RY90:      alu_out = {rot12(alu_inb[23:12], 3), alu_inb[11:0]};
            ALU_RY180:     alu_out = {rot12(alu_inb[23:12], 6), alu_inb[11:0]};
            ALU_RY270:     alu_out = {rot12(alu_inb[23:12], 9), alu_inb[11:0]};
            ALU_RZ90:      alu_out = rot24(alu_inb, 6);
            ALU_RZ180:     alu_out = rot24(alu_inb, 12);
            ALU_REFERENCE: if (ridx <= 3'd6) alu_out = {alu_inb[ridx*3 +: 3], 21'b0};
            ALU_COMP:      alu_out = alu_ina ^ alu_inb;
            default:       alu_out = '0;
        endcase
        alu_zf = (alu_out == 24'd0);
    end

    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (alu_op == ALU_REFERENCE) begin
            ref_cnt <= ref_cnt + 1;
            if (alu_inb[23:21] > 3'd6) bad_idx <= bad_idx + 1;
        end
        if ((alu_op == ALU_REFERENCE || (alu_op >= ALU_RX90 && alu_op <= ALU_RZ180)) && alu_ina != 24'd0)
            bad_ina <= bad_ina + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference rotation: cube viewed as eight 3-bit fields; a turn cycles a ring of fields.
    function automatic logic [23:0] ref_rotate(input logic [2:0] code, input logic [23:0] c);
        logic [2:0] f[8];
        logic [2:0] g[8];
        logic [23:0] r;
        int k;
        for (int i = 0; i < 8; i++) f[i] = c[3*i +: 3];
        g = f;
        if (code <= 3'd2) begin
            k = int'(code) + 1;
            for (int i = 0; i < 4; i++) g[i] = f[(i + k) % 4];
        end else if (code <= 3'd5) begin
            k = int'(code) - 2;
            for (int i = 0; i < 4; i++) g[4 + i] = f[4 + (i + k) % 4];
        end else begin
            k = (code == 3'd6) ? 2 : 4;
            for (int i = 0; i < 8; i++) g[i] = f[(i + k) % 8];
        end
        r = '0;
        for (int i = 0; i < 8; i++) r[3*i +: 3] = g[i];
        return r;
    endfunction

    task automatic model(input logic [23:0] cube, input logic [23:0] target, input logic [23:0] order,
                         output logic [23:0] fin, output int st, output logic sol);
        logic [23:0] c;
        int len;
        logic m;
        c   = cube;
        st  = 0;
        m   = (c == target);
        len = int'(order[23:21]);
        if (!m) begin
            for (int k = 0; k < len; k++) begin
                c = ref_rotate(order[3*k +: 3], c);
                st++;
                m = (c == target);
                if (m) break;
            end
        end
        fin = c;
        sol = m;
    endtask

    task automatic run_case(input string name, input logic [23:0] cube, input logic [23:0] target,
                            input logic [23:0] order, input int mid_start, input int rst_at);
        logic [23:0] exp_cube;
        int exp_steps, cyc, got, d0, r0, bi0, bx0;
        logic exp_sol;
        model(cube, target, order, exp_cube, exp_steps, exp_sol);
        @(posedge clk); #1;
        d0 = done_cnt; r0 = ref_cnt; bi0 = bad_ina; bx0 = bad_idx;
        cube_in = cube; target_in = target; order_in = order; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cube_in = $urandom; target_in = $urandom; order_in = $urandom;
        cyc = 1; got = -1;
        while (cyc < 60) begin
            @(negedge clk);
            if (rst_at >= 0 && cyc == rst_at + 1) begin
                check({name, ".rst_busy"}, 32'(busy), 32'd0);
                check({name, ".rst_done"}, 32'(done), 32'd0);
                check({name, ".rst_solved"}, 32'(solved), 32'd0);
                check({name, ".rst_steps"}, 32'(steps), 32'd0);
                check({name, ".rst_cube"}, 32'(cube_out), 32'd0);
                check({name, ".rst_op"}, 32'(alu_op), 32'(ALU_STORE));
                check({name, ".rst_ina"}, 32'(alu_ina), 32'd0);
                check({name, ".rst_inb"}, 32'(alu_inb), 32'd0);
                repeat (12) @(posedge clk);
                #1;
                check({name, ".rst_no_done"}, 32'(done_cnt - d0), 32'd0);
                return;
            end
            if (done) begin
                got = cyc;
                break;
            end
            if (rst_at == cyc) rst_n = 1'b0;
            if (mid_start == cyc) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            rst_n = 1'b1;
            cyc++;
        end
        check({name, ".latency"}, 32'(got), 32'(2 + 3 * exp_steps));
        @(negedge clk);
        check({name, ".solved"}, 32'(solved), 32'(exp_sol));
        check({name, ".steps"}, 32'(steps), 32'(exp_steps));
        check({name, ".cube"}, 32'(cube_out), 32'(exp_cube));
        check({name, ".busy"}, 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check({name, ".done_pulses"}, 32'(done_cnt - d0), 32'd1);
        check({name, ".ref_ops"}, 32'(ref_cnt - r0), 32'(exp_steps));
        check({name, ".ina_zero"}, 32'(bad_ina - bi0), 32'd0);
        check({name, ".ref_idx"}, 32'(bad_idx - bx0), 32'd0);
    endtask

    initial begin
        logic [23:0] rc, rt, ro, tmp;
        int j;
        rst_n = 1'b0; start = 1'b0;
        order_in = '0; cube_in = '0; target_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.done", 32'(done), 32'd0);
        check("reset.solved", 32'(solved), 32'd0);
        check("reset.steps", 32'(steps), 32'd0);
        check("reset.cube", 32'(cube_out), 32'd0);
        check("reset.op", 32'(alu_op), 32'(ALU_STORE));
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_case("already_solved", 24'h123456, 24'h123456, 24'h200000, -1, -1);
        run_case("rx90_early", 24'h000008, 24'h000001, 24'h400000, -1, -1);
        run_case("rx180_twice", 24'h000008, 24'h000000, 24'h400009, -1, -1);
        run_case("len_zero", 24'h00abcd, 24'h00abce, 24'h1fffff, -1, -1);
        run_case("start_while_busy", 24'h000008, 24'h000000, 24'h400009, 4, -1);
        run_case("reset_in_rotate", 24'h000008, 24'h000000, 24'h400009, -1, 3);
        run_case("after_reset", 24'h000008, 24'h000000, 24'h400009, -1, -1);
        run_case("seven_slots", 24'h5a3c96, 24'h000000, 24'hfac688, -1, -1);

        for (int n = 0; n < 30; n++) begin
            rc = $urandom;
            ro = $urandom;
            if (n % 4 == 0) begin
                rt = $urandom;
            end else begin
                j   = $urandom_range(0, int'(ro[23:21]));
                tmp = rc;
                for (int k = 0; k < j; k++) tmp = ref_rotate(ro[3*k +: 3], tmp);
                rt = tmp;
            end
            run_case($sformatf("rand%0d", n), rc, rt, ro, -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
